regbank16_wr: RTL
=================

REGBANK16_WR -- requirements
Module: regbank16_wr

Interface
REQ-001 Parameter WIDTH, default 8, data width of every entry and of wr_data.
REQ-002 Parameter CLR_VAL, default 0 (WIDTH bits), value loaded into entries by reset and by a clear sweep.
REQ-003 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port wr_valid  input  1  write request present.
REQ-006 Port wr_ready  output  1  bank can accept a write this cycle.
REQ-007 Port wr_addr  input  4  target entry index 0..15.
REQ-008 Port wr_data  input  WIDTH  data to store.
REQ-009 Port wr_done  output  1  one-cycle pulse, cycle after an accepted write.
REQ-010 Port clr_req  input  1  request a full clear sweep.
REQ-011 Port busy  output  1  high while the clear sweep runs.
REQ-012 Port clr_done  output  1  one-cycle pulse after the last sweep write.
REQ-013 Ports q0..q15  output  WIDTH each  current entry contents, registered, directly readable by a 16:1 selector.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and CLEAR.
REQ-015 wr_ready SHALL equal (state==IDLE) AND NOT clr_req, combinationally.
REQ-016 A write SHALL be accepted on a rising edge where wr_valid AND wr_ready; entry wr_addr takes wr_data, all other entries hold.
REQ-017 Write latency SHALL be 1: the new value is visible on q<wr_addr> and wr_done is high in the cycle after acceptance.
REQ-018 Back-to-back accepted writes SHALL be allowed every cycle; a later write to the same address overwrites the earlier one.
REQ-019 In IDLE with clr_req high, the FSM SHALL enter CLEAR with sweep counter = 0; clr_req takes priority over a simultaneous wr_valid, which stalls (no write, no wr_done).
REQ-020 In CLEAR, each cycle entry q<counter> SHALL be loaded with CLR_VAL and the counter incremented; 16 cycles total.
REQ-021 After the counter==15 write, the FSM SHALL return to IDLE and clr_done SHALL be high for exactly the next cycle.
REQ-022 busy SHALL be high exactly during the 16 CLEAR cycles; wr_ready SHALL be low throughout.
REQ-023 clr_req asserted during CLEAR SHALL be ignored (no restart, no extension).
REQ-024 A write held pending (wr_valid high) during CLEAR SHALL be accepted in the first IDLE cycle after the sweep, unless clr_req is high then.
REQ-025 wr_valid with wr_ready low SHALL change no state and produce no wr_done.

Reset
REQ-026 While rst is high: state = IDLE, counter = 0, all q0..q15 = CLR_VAL, wr_done = 0, clr_done = 0, busy = 0, wr_ready = 0.
REQ-027 Reset asserted mid-sweep SHALL abort the sweep immediately; no clr_done is produced.
REQ-028 First write can be accepted on the first rising edge after rst deasserts.

Configuration
REQ-029 Macro REGBANK16_WR_LOCK_EN SHALL control a write-lock feature.
REQ-030 With REGBANK16_WR_LOCK_EN defined: extra input lock (1 bit) and output wr_err (1 bit); an accepted write while lock is high completes the handshake but does not modify any entry, and pulses wr_err (instead of wr_done) in the next cycle; clear sweeps ignore lock; wr_err resets to 0.
REQ-031 Without REGBANK16_WR_LOCK_EN: ports lock and wr_err SHALL not exist and all accepted writes modify the addressed entry.

Verification
REQ-032 Reset then write addr 5 data 0xA5 -> next cycle q5 = 0xA5, wr_done = 1, all other q = 0x00.
REQ-033 Writes to addr 0..15 on 16 consecutive cycles with data = 0x10+addr -> qN = 0x10+N, wr_done high 16 cycles, wr_ready never drops.
REQ-034 After REQ-033 fill, pulse clr_req one cycle -> busy high 16 cycles, q0 clears first, q15 last, clr_done single pulse, all q = 0x00.
REQ-035 clr_req and wr_valid (addr 3, 0x77) same IDLE cycle, wr_valid held -> sweep runs, then write accepted on first IDLE cycle, final q3 = 0x77.
REQ-036 rst asserted at sweep cycle 8 after filling with 0xFF -> all q = 0x00 immediately, busy = 0, no clr_done.
REQ-037 With REGBANK16_WR_LOCK_EN: lock = 1, write addr 2 data 0x3C -> q2 unchanged, wr_err = 1, wr_done = 0.

Source files
------------

// File: rtl/regbank16_wr.sv
// regbank16_wr: sixteen-entry register bank with a single write port and a
// sixteen-cycle clear sweep.
//
// Handshake: a write transfers on a rising edge where wr_valid && wr_ready.
// wr_ready is combinational and is high only in IDLE, with clr_req low and
// rst low. The requester holds wr_valid/wr_addr/wr_data stable until the
// transfer. wr_done pulses in the cycle after each completed write.
//
// A clear sweep starts from IDLE when clr_req is seen. It loads CLR_VAL into
// entry 0, then 1, and so on up to 15, one entry per cycle. busy is the FSM
// state flag: it is high in CLEAR and low in IDLE.
//
// Optional feature: define REGBANK16_WR_LOCK_EN to add the lock input and the
// wr_err output. A write accepted while lock is high completes the handshake
// but leaves every entry unchanged, and it pulses wr_err instead of wr_done.
module regbank16_wr #(
    parameter int                WIDTH   = 8,
    parameter logic [WIDTH-1:0]  CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [3:0]       wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    output logic             wr_done,
    input  logic             clr_req,
    output logic             busy,
    output logic             clr_done,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [WIDTH-1:0] q2,
    output logic [WIDTH-1:0] q3,
    output logic [WIDTH-1:0] q4,
    output logic [WIDTH-1:0] q5,
    output logic [WIDTH-1:0] q6,
    output logic [WIDTH-1:0] q7,
    output logic [WIDTH-1:0] q8,
    output logic [WIDTH-1:0] q9,
    output logic [WIDTH-1:0] q10,
    output logic [WIDTH-1:0] q11,
    output logic [WIDTH-1:0] q12,
    output logic [WIDTH-1:0] q13,
    output logic [WIDTH-1:0] q14,
    output logic [WIDTH-1:0] q15
`ifdef REGBANK16_WR_LOCK_EN
    ,
    input  logic             lock,
    output logic             wr_err
`endif
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] mem [16];
    logic             wr_acc;
    logic             lock_i;
    logic             sweep_last;

`ifdef REGBANK16_WR_LOCK_EN
    assign lock_i = lock;
`else
    assign lock_i = 1'b0;
`endif

    // A write is refused during reset, during the sweep and in the cycle a
    // clear is requested (clear wins over a simultaneous write).
    assign wr_ready   = (state == IDLE) && !clr_req && !rst;
    assign wr_acc     = wr_valid && wr_ready;
    assign busy       = (state == CLEAR);
    assign sweep_last = (state == CLEAR) && (cnt == 4'd15);

    // Next-state logic: clr_req is only sampled in IDLE, so a request during
    // the sweep neither restarts nor extends it.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (clr_req) state_nxt = CLEAR;
            CLEAR:   if (cnt == 4'd15) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register; reset aborts any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Sweep counter: parked at 0 in IDLE so each sweep starts at entry 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 cnt <= 4'd0;
        else if (state == CLEAR) cnt <= cnt + 4'd1;
        else                     cnt <= 4'd0;
    end

    // Entry storage: the sweep owns the bank in CLEAR; otherwise an accepted,
    // unlocked write updates exactly one entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) mem[i] <= CLR_VAL;
        end else if (state == CLEAR) begin
            mem[cnt] <= CLR_VAL;
        end else if (wr_acc && !lock_i) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Completion pulses, each one cycle after the event it reports.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_done  <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            wr_done  <= wr_acc && !lock_i;
            clr_done <= sweep_last;
        end
    end

`ifdef REGBANK16_WR_LOCK_EN
    // Error pulse for a write that was accepted but blocked by lock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) wr_err <= 1'b0;
        else     wr_err <= wr_acc && lock_i;
    end
`endif

    assign q0  = mem[0];
    assign q1  = mem[1];
    assign q2  = mem[2];
    assign q3  = mem[3];
    assign q4  = mem[4];
    assign q5  = mem[5];
    assign q6  = mem[6];
    assign q7  = mem[7];
    assign q8  = mem[8];
    assign q9  = mem[9];
    assign q10 = mem[10];
    assign q11 = mem[11];
    assign q12 = mem[12];
    assign q13 = mem[13];
    assign q14 = mem[14];
    assign q15 = mem[15];

endmodule
